player_draw_datapath: RTL and testbench

- Datapath stage directly downstream of the player movement FSM.
- Latches the player lane from the FSM's ld_pos1..ld_pos4 strobes.
- Walks a 10x10 pixel window while the FSM is in its erase or draw state, and emits x/y/colour/plot to the VGA adapter (160x120, 3-bit colour).
- Counter runs in lockstep with the FSM's 0..99 draw counter: one pixel per clock, 100 pixels per erase or draw pass.

---
 rtl/player_pkg.sv | 20 ++
 rtl/player_sprite_rom.sv | 36 +++
 rtl/player_draw_datapath.sv | 120 ++++++++++++
 tb/tb_player_draw_datapath.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared constants for the player movement FSM and its draw datapath.
// Screen geometry, coordinate widths, sprite size and palette live here.
package player_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int CNT_W    = 4;

    localparam int SPRITE_W   = 10;
    localparam int SPRITE_H   = 10;
    localparam int PIXEL_LAST = SPRITE_W * SPRITE_H - 1;  // FSM draw counter terminal count
    localparam int LANES      = 4;

    localparam logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000;
    localparam logic [COLOUR_W-1:0] SPRITE_COLOUR = 3'b010;

endpackage

// File: rtl/player_sprite_rom.sv
// Combinational 10x10 ship mask; row/col outside the sprite read as clear.
// The shape is left/right symmetric, so column bit order is immaterial.
module player_sprite_rom
    import player_pkg::*;
(
    input  logic [CNT_W-1:0] row,
    input  logic [CNT_W-1:0] col,
    output logic             mask
);

    logic [9:0] row_bits;

    always_comb begin
        row_bits = 10'b0000000000;
        case (row)
            4'd0: row_bits = 10'b0000110000;
            4'd1: row_bits = 10'b0000110000;
            4'd2: row_bits = 10'b0001111000;
            4'd3: row_bits = 10'b0001111000;
            4'd4: row_bits = 10'b0011111100;
            4'd5: row_bits = 10'b0111111110;
            4'd6: row_bits = 10'b1111111111;
            4'd7: row_bits = 10'b1111111111;
            4'd8: row_bits = 10'b0011001100;
            4'd9: row_bits = 10'b0100000010;
            default: row_bits = 10'b0000000000;
        endcase
    end

    always_comb begin
        mask = 1'b0;
        if (col <= 4'd9)
            mask = row_bits[4'd9 - col];
    end

endmodule

// File: rtl/player_draw_datapath.sv
// Player sprite draw datapath: latches the lane from the movement FSM and
// walks the sprite window during erase/draw, one registered pixel per clock.
module player_draw_datapath
    import player_pkg::*;
#(
    parameter int                   X_BASE        = 20,
    parameter int                   LANE_STEP     = 30,
    parameter int                   PLAYER_Y      = 100,
    parameter int                   SPRITE_W      = player_pkg::SPRITE_W,
    parameter int                   SPRITE_H      = player_pkg::SPRITE_H,
    parameter logic [COLOUR_W-1:0]  SPRITE_COLOUR = player_pkg::SPRITE_COLOUR,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR     = player_pkg::BG_COLOUR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_pos1,
    input  logic                ld_pos2,
    input  logic                ld_pos3,
    input  logic                ld_pos4,
    input  logic                in_erase,
    input  logic                in_draw,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                pass_done
);

    logic [1:0]          lane_p0;
    logic [CNT_W-1:0]    col_p0;
    logic [CNT_W-1:0]    row_p0;
    logic                active_p0;
    logic                col_last_p0;
    logic                row_last_p0;
    logic                mask_p0;
    logic [X_W-1:0]      x_next_p0;
    logic [Y_W-1:0]      y_next_p0;
    logic [COLOUR_W-1:0] colour_next_p0;

    logic [X_W-1:0]      x_p1;
    logic [Y_W-1:0]      y_p1;
    logic [COLOUR_W-1:0] colour_p1;
    logic                vld_p1;
    logic                done_p1;

    assign active_p0   = in_erase | in_draw;
    assign col_last_p0 = (col_p0 == CNT_W'(SPRITE_W - 1));
    assign row_last_p0 = (row_p0 == CNT_W'(SPRITE_H - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lane_p0 <= 2'd0;
        else if (ld_pos1)
            lane_p0 <= 2'd0;
        else if (ld_pos2)
            lane_p0 <= 2'd1;
        else if (ld_pos3)
            lane_p0 <= 2'd2;
        else if (ld_pos4)
            lane_p0 <= 2'd3;
    end

    // Counters clear whenever idle so every pass starts at the top-left pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (!active_p0) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (col_last_p0) begin
            col_p0 <= '0;
            row_p0 <= row_last_p0 ? '0 : row_p0 + 1'b1;
        end else begin
            col_p0 <= col_p0 + 1'b1;
        end
    end

    player_sprite_rom u_rom (
        .row  (row_p0),
        .col  (col_p0),
        .mask (mask_p0)
    );

    // Erase wins when both state flags are raised.
    always_comb begin
        x_next_p0      = X_W'(X_BASE) + X_W'(lane_p0) * X_W'(LANE_STEP) + X_W'(col_p0);
        y_next_p0      = Y_W'(PLAYER_Y) + Y_W'(row_p0);
        colour_next_p0 = BG_COLOUR;
        if (in_draw && !in_erase && mask_p0)
            colour_next_p0 = SPRITE_COLOUR;
    end

    // ---- stage p0 -> p1: registered pixel to the VGA adapter ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p1      <= '0;
            y_p1      <= '0;
            colour_p1 <= BG_COLOUR;
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
        end else if (active_p0) begin
            x_p1      <= x_next_p0;
            y_p1      <= y_next_p0;
            colour_p1 <= colour_next_p0;
            vld_p1    <= 1'b1;
            done_p1   <= col_last_p0 & row_last_p0;
        end else begin
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
        end
    end

    assign x         = x_p1;
    assign y         = y_p1;
    assign colour    = colour_p1;
    assign plot      = vld_p1;
    assign pass_done = done_p1;

endmodule

// File: tb/tb_player_draw_datapath.sv
// Directed bench for player_draw_datapath: table of passes checked pixel by
// pixel against a local sprite model, plus reset and mid-pass reset sequences.
module tb_player_draw_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_pos1, ld_pos2, ld_pos3, ld_pos4;
    logic       in_erase, in_draw;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       pass_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] ship [10];

    typedef struct {
        logic [3:0] ld;     // {ld_pos4, ld_pos3, ld_pos2, ld_pos1}
        logic       erase;
        logic       draw;
        logic       chain;  // next pass follows with no idle cycle
        int         exp_lane;
    } pass_t;

    pass_t passes [7];

    player_draw_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .ld_pos1   (ld_pos1),
        .ld_pos2   (ld_pos2),
        .ld_pos3   (ld_pos3),
        .ld_pos4   (ld_pos4),
        .in_erase  (in_erase),
        .in_draw   (in_draw),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .pass_done (pass_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] ld);
        {ld_pos4, ld_pos3, ld_pos2, ld_pos1} = ld;
        step();
        {ld_pos4, ld_pos3, ld_pos2, ld_pos1} = 4'b0000;
    endtask

    // Runs one 100-pixel pass starting now; checks every emitted pixel.
    task automatic run_pass(input logic e, input logic d, input logic chain,
                            input int lane, input string tag);
        int plots = 0;
        int dones = 0;
        int bad_px = 0;
        int ex, ey, ec, ed;
        in_erase = e;
        in_draw  = d;
        for (int k = 0; k < 100; k++) begin
            step();
            ex = 20 + lane * 30 + (k % 10);
            ey = 100 + (k / 10);
            ec = (d && !e && ship[k / 10][9 - (k % 10)]) ? 2 : 0;
            ed = (k == 99) ? 1 : 0;
            if (plot) plots++;
            if (pass_done) dones++;
            if (x != ex || y != ey || colour != ec || pass_done != ed) begin
                bad_px++;
                if (bad_px <= 3)
                    $display("FAIL %s px%0d: got (%0d,%0d) c=%0d pd=%0d expected (%0d,%0d) c=%0d pd=%0d",
                             tag, k, x, y, colour, pass_done, ex, ey, ec, ed);
            end
        end
        n_cmp++;
        if (bad_px != 0) n_bad++;
        chk({tag, " plots"}, plots, 100);
        chk({tag, " pass_done count"}, dones, 1);
        if (!chain) begin
            in_erase = 1'b0;
            in_draw  = 1'b0;
            step();
            chk({tag, " idle plot"}, plot, 0);
            chk({tag, " idle pass_done"}, pass_done, 0);
            chk({tag, " x hold"}, x, 20 + lane * 30 + 9);
            chk({tag, " y hold"}, y, 109);
        end
    endtask

    initial begin
        int idle_plots;
        ship[0] = 10'b0000110000;
        ship[1] = 10'b0000110000;
        ship[2] = 10'b0001111000;
        ship[3] = 10'b0001111000;
        ship[4] = 10'b0011111100;
        ship[5] = 10'b0111111110;
        ship[6] = 10'b1111111111;
        ship[7] = 10'b1111111111;
        ship[8] = 10'b0011001100;
        ship[9] = 10'b0100000010;

        passes[0] = '{ld: 4'b0001, erase: 1'b0, draw: 1'b1, chain: 1'b0, exp_lane: 0};
        passes[1] = '{ld: 4'b0000, erase: 1'b1, draw: 1'b0, chain: 1'b0, exp_lane: 0};
        passes[2] = '{ld: 4'b0010, erase: 1'b0, draw: 1'b1, chain: 1'b0, exp_lane: 1};
        passes[3] = '{ld: 4'b1000, erase: 1'b0, draw: 1'b1, chain: 1'b0, exp_lane: 3};
        passes[4] = '{ld: 4'b0110, erase: 1'b1, draw: 1'b1, chain: 1'b0, exp_lane: 1};
        passes[5] = '{ld: 4'b0000, erase: 1'b1, draw: 1'b0, chain: 1'b1, exp_lane: 1};
        passes[6] = '{ld: 4'b0000, erase: 1'b0, draw: 1'b1, chain: 1'b0, exp_lane: 1};

        reset = 1'b1;
        {ld_pos4, ld_pos3, ld_pos2, ld_pos1} = 4'b0000;
        in_erase = 1'b0;
        in_draw  = 1'b0;
        step();
        step();
        chk("reset plot", plot, 0);
        chk("reset pass_done", pass_done, 0);
        chk("reset x", x, 0);
        chk("reset y", y, 0);
        chk("reset colour", colour, 0);
        reset = 1'b0;

        idle_plots = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (plot) idle_plots++;
        end
        chk("idle plots", idle_plots, 0);
        chk("idle x", x, 0);

        for (int p = 0; p < 7; p++) begin
            if (passes[p].ld != 4'b0000)
                strobe(passes[p].ld);
            run_pass(passes[p].erase, passes[p].draw, passes[p].chain,
                     passes[p].exp_lane, $sformatf("pass%0d", p));
        end

        // Reset in the middle of a draw pass, then a clean pass afterwards.
        strobe(4'b0100);
        in_draw = 1'b1;
        for (int k = 0; k < 47; k++) step();
        chk("mid-pass plot before reset", plot, 1);
        chk("mid-pass x before reset", x, 80 + 6);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset plot", plot, 0);
        chk("async reset x", x, 0);
        in_draw = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post-reset plot", plot, 0);
        run_pass(1'b0, 1'b1, 1'b0, 0, "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
